alsu_req_arbiter: RTL and testbench

- Front-end controller that shares one ALSU instance between two requesters (port 0, port 1).
- Accepts one command per requester over a valid/ready handshake and arbitrates round-robin.
- Drives the ALSU input pins and holds them stable for the fixed ALSU latency, then captures the ALSU `out` bus.
- Returns the result with an error flag through a response valid/ready handshake tagged with the requester id.

---
 rtl/alsu_req_arbiter.sv | 158 +++++++++++++++
 tb/tb_alsu_req_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alsu_req_arbiter.sv
// Two-port round-robin front end for a shared ALSU.
// Holds each command on the ALSU pins for its fixed latency, then returns the result.
module alsu_req_arbiter #(
  parameter int RESULT_LATENCY = 3,
  parameter int INVALID_WAIT   = 8,
  parameter bit FIRST_GRANT    = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [14:0] req0_cmd,
  input  logic [14:0] req1_cmd,
  input  logic [1:0]  req_bypass_B,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [5:0]  resp_data,
  output logic        resp_err,
  output logic [2:0]  alsu_opcode,
  output logic [2:0]  alsu_A,
  output logic [2:0]  alsu_B,
  output logic [6:0]  alsu_ctrl,
  input  logic [5:0]  alsu_out,
  output logic        busy
);

  localparam int CMAX = (RESULT_LATENCY > INVALID_WAIT) ?
                        RESULT_LATENCY : INVALID_WAIT;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] LIM_OK  = CW'(RESULT_LATENCY - 1);
  localparam logic [CW-1:0] LIM_BAD = CW'(INVALID_WAIT - 1);
  localparam logic [6:0] IDLE_CTRL = 7'b0000010;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    ILLEGAL,
    RESP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ptr_q;
  logic [14:0]   cmd_q;
  logic          bpb_q;
  logic          owner_q;
  logic [5:0]    data_q;
  logic          err_q;

  logic          gnt;
  logic          gnt_id;
  logic [14:0]   gnt_cmd;
  logic          gnt_bpb;
  logic [2:0]    gnt_op;
  logic          gnt_red;
  logic          gnt_byp;
  logic          gnt_bad;
  logic [CW-1:0] lim;
  logic          done;
  logic          drive;

  always_comb begin
    gnt_id = ptr_q;
    unique case (1'b1)
      (req_valid == 2'b11): gnt_id = ptr_q;
      (req_valid == 2'b01): gnt_id = 1'b0;
      (req_valid == 2'b10): gnt_id = 1'b1;
      default:              gnt_id = ptr_q;
    endcase
  end

  assign gnt       = rst && (state_q == IDLE) && (|req_valid);
  assign req_ready = !gnt ? 2'b00 : (gnt_id ? 2'b10 : 2'b01);

  assign gnt_cmd = gnt_id ? req1_cmd : req0_cmd;
  assign gnt_bpb = req_bypass_B[gnt_id];
  assign gnt_op  = gnt_cmd[14:12];
  assign gnt_red = gnt_cmd[2] | gnt_cmd[1];
  assign gnt_byp = gnt_cmd[0] | gnt_bpb;
  // Reduction flags are only meaningful for the AND/XOR opcodes
  assign gnt_bad = (gnt_op >= 3'd6) ||
                   ((gnt_op >= 3'd2) && gnt_red && !gnt_byp);

  assign lim  = (state_q == ISSUE) ? LIM_OK : LIM_BAD;
  assign done = (cnt_q == lim);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (gnt) state_d = gnt_bad ? ILLEGAL : ISSUE;
      end
      ISSUE, ILLEGAL: begin
        if (done) state_d = RESP;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == ISSUE || state_q == ILLEGAL) begin
      cnt_d = done ? cnt_q : cnt_q + 1'b1;
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= FIRST_GRANT;
      cmd_q   <= '0;
      bpb_q   <= 1'b0;
      owner_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (gnt) begin
        cmd_q   <= gnt_cmd;
        bpb_q   <= gnt_bpb;
        owner_q <= gnt_id;
        ptr_q   <= ~gnt_id;
      end
      if (state_q == ISSUE && done) begin
        data_q <= alsu_out;
        err_q  <= 1'b0;
      end
      if (state_q == ILLEGAL && done) begin
        data_q <= '0;
        err_q  <= 1'b1;
      end
    end
  end

  assign drive = (state_q == ISSUE) || (state_q == ILLEGAL);

  assign alsu_opcode = drive ? cmd_q[14:12] : 3'b000;
  assign alsu_A      = drive ? cmd_q[11:9]  : 3'b000;
  assign alsu_B      = drive ? cmd_q[8:6]   : 3'b000;
  assign alsu_ctrl   = drive ? {cmd_q[5:0], bpb_q} : IDLE_CTRL;

  assign resp_valid = (state_q == RESP);
  assign resp_id    = owner_q;
  assign resp_data  = data_q;
  assign resp_err   = err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alsu_req_arbiter.sv
// Directed bench for alsu_req_arbiter with a two-stage ALSU stand-in.
// Expected results are hand-computed constants.
module tb_alsu_req_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [14:0] req0_cmd = '0;
  logic [14:0] req1_cmd = '0;
  logic [1:0]  req_bypass_B = 2'b00;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic        resp_id;
  logic [5:0]  resp_data;
  logic        resp_err;
  logic [2:0]  alsu_opcode;
  logic [2:0]  alsu_A;
  logic [2:0]  alsu_B;
  logic [6:0]  alsu_ctrl;
  logic [5:0]  alsu_out = '0;
  logic [5:0]  s1 = '0;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;

  alsu_req_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req0_cmd     (req0_cmd),
    .req1_cmd     (req1_cmd),
    .req_bypass_B (req_bypass_B),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_id      (resp_id),
    .resp_data    (resp_data),
    .resp_err     (resp_err),
    .alsu_opcode  (alsu_opcode),
    .alsu_A       (alsu_A),
    .alsu_B       (alsu_B),
    .alsu_ctrl    (alsu_ctrl),
    .alsu_out     (alsu_out),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] alsu_f(
    input logic [2:0] op,
    input logic [2:0] a,
    input logic [2:0] b,
    input logic [6:0] c
  );
    logic [5:0] r;
    r = '0;
    if (c[1]) r = {3'b000, a};
    else if (c[0]) r = {3'b000, b};
    else begin
      case (op)
        3'd0: r = c[3] ? {5'd0, &a} :
                  c[2] ? {5'd0, &b} : {3'b000, a & b};
        3'd1: r = {3'b000, a ^ b};
        3'd2: r = 6'(a) + 6'(b) + 6'(c[6]);
        3'd3: r = 6'(a) * 6'(b);
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  always @(posedge clk) begin
    s1       <= alsu_f(alsu_opcode, alsu_A, alsu_B, alsu_ctrl);
    alsu_out <= s1;
  end

  function automatic logic [14:0] mk(
    input logic [2:0] op,
    input logic [2:0] a,
    input logic [2:0] b,
    input logic cin,
    input logic ra,
    input logic rb,
    input logic ba
  );
    return {op, a, b, cin, 1'b0, 1'b0, ra, rb, ba};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input int p, input logic [14:0] c,
                         input logic [5:0] ed, input logic ee,
                         input int elat, input string tag);
    int k;
    logic seen;
    if (p == 0) req0_cmd = c;
    else req1_cmd = c;
    req_valid[p] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = req_ready[p];
    end
    chk({tag, " grant"}, 32'(seen), 32'd1);
    @(posedge clk);
    #1 req_valid[p] = 1'b0;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      seen = resp_valid;
      if (!seen) chk({tag, " pins"}, 32'(alsu_opcode), 32'(c[14:12]));
    end
    chk({tag, " latency"}, 32'(k), 32'(elat));
    chk({tag, " id"}, 32'(resp_id), 32'(p));
    chk({tag, " data"}, 32'(resp_data), 32'(ed));
    chk({tag, " err"}, 32'(resp_err), 32'(ee));
    @(posedge clk);
    #1;
    chk({tag, " done"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    int k;
    logic seen;

    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst req_ready", 32'(req_ready), 32'd0);
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst resp_id", 32'(resp_id), 32'd0);
    chk("rst resp_data", 32'(resp_data), 32'd0);
    chk("rst resp_err", 32'(resp_err), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst opcode", 32'(alsu_opcode), 32'd0);
    chk("rst A", 32'(alsu_A), 32'd0);
    chk("rst B", 32'(alsu_B), 32'd0);
    chk("rst ctrl", 32'(alsu_ctrl), 32'b0000010);
    rst = 1'b1;

    run_cmd(0, mk(3'd0, 3'd5, 3'd3, 0, 0, 0, 0), 6'd1, 1'b0, 4, "and");
    run_cmd(1, mk(3'd2, 3'd7, 3'd7, 1, 0, 0, 0), 6'd15, 1'b0, 4, "add");
    run_cmd(1, mk(3'd3, 3'd5, 3'd6, 0, 0, 0, 0), 6'd30, 1'b0, 4, "mul");
    run_cmd(0, mk(3'd6, 3'd1, 3'd2, 0, 0, 0, 0), 6'd0, 1'b1, 9, "op110");
    run_cmd(0, mk(3'd1, 3'd6, 3'd3, 0, 0, 0, 0), 6'd5, 1'b0, 4, "xor");
    run_cmd(1, mk(3'd4, 3'd5, 3'd2, 0, 1, 0, 0), 6'd0, 1'b1, 9, "redbad");
    run_cmd(1, mk(3'd2, 3'd5, 3'd2, 0, 1, 0, 1), 6'd5, 1'b0, 4, "redbyp");

    // both ports contend straight after reset
    rst = 1'b0;
    req0_cmd = mk(3'd0, 3'd7, 3'd3, 0, 0, 0, 0);
    req1_cmd = mk(3'd3, 3'd2, 3'd3, 0, 0, 0, 0);
    req_valid = 2'b11;
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      seen = 1'b0;
      for (int j = 0; j < 20 && !seen; j++) begin
        @(negedge clk);
        seen = |req_ready;
      end
      chk("rr grant", 32'(req_ready), (i % 2) ? 32'd2 : 32'd1);
      seen = 1'b0;
      for (int j = 0; j < 20 && !seen; j++) begin
        @(negedge clk);
        seen = resp_valid;
      end
      chk("rr resp", 32'(seen), 32'd1);
      chk("rr id", 32'(resp_id), 32'(i % 2));
      chk("rr data", 32'(resp_data), (i % 2) ? 32'd6 : 32'd3);
      @(posedge clk);
    end
    #1 req_valid = 2'b00;

    // back-pressure on the response
    resp_ready = 1'b0;
    req1_cmd = mk(3'd2, 3'd3, 3'd4, 0, 0, 0, 0);
    req_valid = 2'b10;
    seen = 1'b0;
    for (int j = 0; j < 20 && !seen; j++) begin
      @(negedge clk);
      seen = req_ready[1];
    end
    chk("hold grant", 32'(seen), 32'd1);
    @(posedge clk);
    #1 req_valid = 2'b01;
    seen = 1'b0;
    for (int j = 0; j < 20 && !seen; j++) begin
      @(negedge clk);
      seen = resp_valid;
    end
    chk("hold resp", 32'(seen), 32'd1);
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      chk("hold valid", 32'(resp_valid), 32'd1);
      chk("hold data", 32'(resp_data), 32'd7);
      chk("hold id", 32'(resp_id), 32'd1);
      chk("hold ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 req_valid = 2'b00;
    chk("hold release", 32'(resp_valid), 32'd0);
    @(negedge clk);
    chk("withdraw busy", 32'(busy), 32'd0);

    // reset in the middle of ISSUE
    req0_cmd = mk(3'd1, 3'd6, 3'd3, 0, 0, 0, 0);
    req_valid = 2'b01;
    seen = 1'b0;
    for (int j = 0; j < 20 && !seen; j++) begin
      @(negedge clk);
      seen = req_ready[0];
    end
    chk("mid grant", 32'(seen), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("mid busy pre", 32'(busy), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("mid busy", 32'(busy), 32'd0);
    chk("mid resp_valid", 32'(resp_valid), 32'd0);
    chk("mid req_ready", 32'(req_ready), 32'd0);
    chk("mid resp_data", 32'(resp_data), 32'd0);
    chk("mid opcode", 32'(alsu_opcode), 32'd0);
    chk("mid A", 32'(alsu_A), 32'd0);
    chk("mid ctrl", 32'(alsu_ctrl), 32'b0000010);
    rst = 1'b1;
    @(negedge clk);
    chk("mid regrant", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 2'b00;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      seen = resp_valid;
    end
    chk("mid latency", 32'(k), 32'd4);
    chk("mid data", 32'(resp_data), 32'd5);
    chk("mid id", 32'(resp_id), 32'd0);
    @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
